// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-channel PWM LED driver that ramps each level toward its on/off target.
module led_fade_pwm #(
  parameter int CHANNELS    = 10,
  parameter int PWM_BITS    = 8,
  parameter int FADE_STEP   = 8,
  parameter int STEP_FRAMES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] pattern_in,
  input  logic                fade_en,
  output logic [CHANNELS-1:0] led_out,
  output logic                busy
);
  localparam int FW = STEP_FRAMES > 1 ? $clog2(STEP_FRAMES) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(FADE_STEP);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FW-1:0] frame_cnt;
  logic [PWM_BITS-1:0] level [CHANNELS];
  logic [PWM_BITS-1:0] next_level [CHANNELS];
  logic [CHANNELS-1:0] diff;
  logic fade_tick;
  assign fade_tick = pwm_cnt == MAX && frame_cnt == FW'(STEP_FRAMES - 1);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0] up;
    assign target = pattern_in[i] ? MAX : '0;
    assign up = {1'b0, level[i]} + STEP;
    // Sums are one bit wider so saturation is detected instead of wrapping.
    assign next_level[i] = !fade_en ? target
                         : !fade_tick ? level[i]
                         : pattern_in[i] ? (up > {1'b0, MAX} ? MAX : up[PWM_BITS-1:0])
                         : ({1'b0, level[i]} < STEP ? '0 : level[i] - STEP[PWM_BITS-1:0]);
    assign diff[i] = level[i] != target;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt   <= '0;
      frame_cnt <= '0;
      led_out   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) level[i] <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == MAX) frame_cnt <= fade_tick ? '0 : frame_cnt + 1'b1;
      busy <= |diff;
      for (int i = 0; i < CHANNELS; i++) begin
        level[i]   <= next_level[i];
        led_out[i] <= level[i] == MAX || level[i] > pwm_cnt;
      end
    end
  end
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: randomized bench comparing two step sizes against an arithmetic model.
module tb_led_fade_pwm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] pat = '0;
  logic fe = 1'b1;
  logic [9:0] led_a, led_b;
  logic busy_a, busy_b;
  int n_chk = 0, n_pass = 0;
  int t = 0;
  int lvl [2][10];
  logic [9:0] eled [2];
  logic ebusy [2];
  int stp [2] = '{4, 15};

  always #5 clk = ~clk;

  led_fade_pwm #(.CHANNELS(10), .PWM_BITS(4), .FADE_STEP(4), .STEP_FRAMES(1)) dut_a (
    .clk(clk), .reset_n(rst_n), .pattern_in(pat), .fade_en(fe), .led_out(led_a), .busy(busy_a));
  led_fade_pwm #(.CHANNELS(10), .PWM_BITS(4), .FADE_STEP(15), .STEP_FRAMES(1)) dut_b (
    .clk(clk), .reset_n(rst_n), .pattern_in(pat), .fade_en(fe), .led_out(led_b), .busy(busy_b));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
  endtask

  // One clock: model the edge from the inputs present, then compare at the falling edge.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        eled[k] = '0;
        ebusy[k] = 1'b0;
        for (int i = 0; i < 10; i++) lvl[k][i] = 0;
      end else begin
        ebusy[k] = 1'b0;
        for (int i = 0; i < 10; i++) begin
          int tg;
          tg = pat[i] ? 15 : 0;
          eled[k][i] = lvl[k][i] == 15 || lvl[k][i] > t % 16;
          if (lvl[k][i] != tg) ebusy[k] = 1'b1;
          if (!fe) lvl[k][i] = tg;
          else if (t % 16 == 15)
            lvl[k][i] = pat[i] ? (lvl[k][i] + stp[k] > 15 ? 15 : lvl[k][i] + stp[k])
                               : (lvl[k][i] - stp[k] < 0 ? 0 : lvl[k][i] - stp[k]);
        end
      end
    end
    t = rst_n ? t + 1 : 0;
    @(negedge clk);
    check("led_s4", int'(led_a), int'(eled[0]));
    check("busy_s4", int'(busy_a), int'(ebusy[0]));
    check("led_s15", int'(led_b), int'(eled[1]));
    check("busy_s15", int'(busy_b), int'(ebusy[1]));
  endtask

  initial begin
    int cnt;
    pat = 10'h3FF;
    step();
    step();
    check("busy_in_reset", int'(busy_a), 0);
    check("led_in_reset", int'(led_a), 0);
    rst_n = 1'b1;
    step();
    check("busy_after_release", int'(busy_a), 1);
    repeat (70) step();
    check("led_full_s4", int'(led_a), 'h3FF);
    check("busy_done_s4", int'(busy_a), 0);
    check("led_full_s15", int'(led_b), 'h3FF);

    // duty at level 8, then reversal toward 0
    rst_n = 1'b0;
    pat = 10'h001;
    step();
    rst_n = 1'b1;
    repeat (32) step();
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (c < 8) check("duty_phase", int'(led_a[0]), 1);
      cnt += int'(led_a[0]);
      check("duty_others", int'(led_a[9:1]), 0);
    end
    check("duty_count", cnt, 8);
    pat = 10'h000;
    repeat (18) step();
    check("reverse_busy", int'(busy_a), 0);
    check("reverse_led", int'(led_a), 0);

    // bypass then fade back in
    fe = 1'b0;
    pat = 10'h2AA;
    step();
    step();
    check("bypass_led", int'(led_a), 'h2AA);
    check("bypass_busy", int'(busy_a), 0);
    repeat (20) step();
    fe = 1'b1;
    pat = 10'h155;
    repeat (80) step();

    // reset mid-fade
    pat = 10'h3FF;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    check("midreset_led", int'(led_a), 0);
    check("midreset_busy", int'(busy_a), 0);
    rst_n = 1'b1;
    repeat (40) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) pat = 10'($urandom);
      if ($urandom_range(0, 99) == 0) fe = ~fe;
      rst_n = $urandom_range(0, 499) != 0;
      step();
    end
    rst_n = 1'b1;
    fe = 1'b1;
    pat = '0;
    repeat (80) step();
    check("final_idle_led", int'(led_a), 0);
    check("final_idle_busy", int'(busy_a), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
